// File: rtl/flow_control_loop_pipe_sequential_init_pkg.sv
// ---------------------------------------------------------------------------
// flow_control_loop_pipe_sequential_init_pkg
//
// Purpose: handshake polarity and reset-value constants shared by the
// pipelined-loop flow-control leaf. All HLS handshake strobes are active-high.
//
// Contents:
//   hs_active        asserted level of every handshake strobe
//   loop_init_reset  value of the loop-init flop while in reset
//   done_cache_reset value of the done-cache flop while in reset
// ---------------------------------------------------------------------------
package flow_control_loop_pipe_sequential_init_pkg;

  localparam logic hs_active        = 1'b1;
  localparam logic loop_init_reset  = 1'b1;
  localparam logic done_cache_reset = 1'b0;

endpackage

// File: rtl/flow_control_loop_pipe_sequential_init.sv
// ---------------------------------------------------------------------------
// flow_control_loop_pipe_sequential_init
//
// Purpose: flow-control leaf between a parent block-level handshake and a
// pipelined loop. Forwards start, reports ready on loop exit, flags the first
// iteration of every loop run, and holds done high after the loop drains
// until the parent issues its next start.
//
// Ports:
//   ap_clk             in   rising-edge clock
//   ap_rst_n           in   asynchronous active-low reset
//   ap_start           in   start request from parent
//   ap_ready           out  ready for next start (to parent)
//   ap_done            out  block done (to parent)
//   ap_start_int       out  start forwarded to loop pipeline
//   ap_loop_init       out  high during the first iteration of each run
//   ap_ready_int       in   pipeline accepted an iteration this cycle
//   ap_loop_exit_ready in   pipeline issued its final iteration this cycle
//   ap_loop_exit_done  in   pipeline drained this cycle
//   ap_continue_int    out  continue to pipeline (always asserted)
//   ap_done_int        in   pipeline done echo, intentionally ignored
// ---------------------------------------------------------------------------
module flow_control_loop_pipe_sequential_init
  import flow_control_loop_pipe_sequential_init_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic ap_start,
  output logic ap_ready,
  output logic ap_done,
  output logic ap_start_int,
  output logic ap_loop_init,
  input  logic ap_ready_int,
  input  logic ap_loop_exit_ready,
  input  logic ap_loop_exit_done,
  output logic ap_continue_int,
  input  logic ap_done_int
);

  logic done_cache;

  // ap_done_int carries no information this block needs; the *unused* name
  // documents that it is deliberately sunk.
  logic unused_done_int;
  assign unused_done_int = ap_done_int;

  assign ap_start_int    = ap_start;
  assign ap_continue_int = hs_active;
  assign ap_ready        = ap_loop_exit_ready;

  // Exit takes priority over acceptance so a run that ends on the same cycle
  // an iteration is accepted still leaves init armed for the next run.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_loop_init <= loop_init_reset;
    end else if (ap_loop_exit_ready == hs_active) begin
      ap_loop_init <= hs_active;
    end else if (ap_ready_int == hs_active) begin
      ap_loop_init <= ~hs_active;
    end
  end

  // A new start wins over a coincident drain so done cannot leak into the
  // next run.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      done_cache <= done_cache_reset;
    end else if (ap_start == hs_active) begin
      done_cache <= ~hs_active;
    end else if (ap_loop_exit_done == hs_active) begin
      done_cache <= hs_active;
    end
  end

  // Done reaches the parent on the drain cycle itself, then is held from the
  // cache while the parent has not restarted.
  assign ap_done = ap_loop_exit_done | (~ap_start & done_cache);

endmodule

// File: tb/tb_flow_control_loop_pipe_sequential_init.sv
// ---------------------------------------------------------------------------
// tb_flow_control_loop_pipe_sequential_init
//
// Purpose: self-checking bench. Directed scenarios for reset, a six-iteration
// run, done holding, both collision cases and async reset, followed by
// randomized cycles checked against a run-level reference model.
// ---------------------------------------------------------------------------
module tb_flow_control_loop_pipe_sequential_init;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_start_int;
  logic ap_loop_init;
  logic ap_ready_int;
  logic ap_loop_exit_ready;
  logic ap_loop_exit_done;
  logic ap_continue_int;
  logic ap_done_int;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model in run-level terms:
  //   awaitingFirstIter - the next accepted iteration opens a run
  //   doneSinceStart    - the loop drained after the parent's latest start
  logic awaitingFirstIter;
  logic doneSinceStart;

  always #5 ap_clk = ~ap_clk;

  flow_control_loop_pipe_sequential_init dut (
    .ap_clk             (ap_clk),
    .ap_rst_n           (ap_rst_n),
    .ap_start           (ap_start),
    .ap_ready           (ap_ready),
    .ap_done            (ap_done),
    .ap_start_int       (ap_start_int),
    .ap_loop_init       (ap_loop_init),
    .ap_ready_int       (ap_ready_int),
    .ap_loop_exit_ready (ap_loop_exit_ready),
    .ap_loop_exit_done  (ap_loop_exit_done),
    .ap_continue_int    (ap_continue_int),
    .ap_done_int        (ap_done_int)
  );

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every output against the model for the inputs currently applied.
  task automatic checkOutput(input string tag);
    logic expDone;
    expDone = ap_loop_exit_done || (!ap_start && doneSinceStart);
    checkBit({tag, ".start_int"}, ap_start_int,    ap_start);
    checkBit({tag, ".continue"},  ap_continue_int, 1'b1);
    checkBit({tag, ".ready"},     ap_ready,        ap_loop_exit_ready);
    checkBit({tag, ".loop_init"}, ap_loop_init,    awaitingFirstIter);
    checkBit({tag, ".done"},      ap_done,         expDone);
  endtask

  // Drive a new input vector away from the active edge; reset is modelled
  // immediately because it acts without a clock.
  task automatic applyStimulus(input logic rst, input logic start, input logic rdy,
                               input logic exr, input logic exd, input logic dint);
    @(negedge ap_clk);
    ap_rst_n           = rst;
    ap_start           = start;
    ap_ready_int       = rdy;
    ap_loop_exit_ready = exr;
    ap_loop_exit_done  = exd;
    ap_done_int        = dint;
    if (!rst) begin
      awaitingFirstIter = 1'b1;
      doneSinceStart    = 1'b0;
    end
    #1;
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic clockModel();
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      awaitingFirstIter = 1'b1;
      doneSinceStart    = 1'b0;
    end else begin
      if (ap_loop_exit_ready)  awaitingFirstIter = 1'b1;
      else if (ap_ready_int)   awaitingFirstIter = 1'b0;
      if (ap_start)               doneSinceStart = 1'b0;
      else if (ap_loop_exit_done) doneSinceStart = 1'b1;
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic start, input logic rdy,
                      input logic exr, input logic exd);
    applyStimulus(rst, start, rdy, exr, exd, 1'b0);
    checkOutput(tag);
    clockModel();
  endtask

  initial begin
    awaitingFirstIter = 1'b1;
    doneSinceStart    = 1'b0;

    // Reset with all inputs low
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset");
    checkBit("reset.init_lit", ap_loop_init, 1'b1);
    checkBit("reset.done_lit", ap_done, 1'b0);
    checkBit("reset.ready_lit", ap_ready, 1'b0);
    clockModel();
    step("release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Six accepted iterations, then exit
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("run.c%0d", c));
      checkBit($sformatf("run.c%0d.init_lit", c), ap_loop_init, (c == 0));
      clockModel();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("run.c6");
    checkBit("run.c6.ready_lit", ap_ready, 1'b1);
    clockModel();

    // Drain with start low: done caught and held
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain.c7");
    checkBit("drain.c7.init_lit", ap_loop_init, 1'b1);
    checkBit("drain.c7.done_lit", ap_done, 1'b1);
    clockModel();
    for (int c = 8; c < 11; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("hold.c%0d", c));
      checkBit($sformatf("hold.c%0d.done_lit", c), ap_done, 1'b1);
      clockModel();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart");
    checkBit("restart.done_lit", ap_done, 1'b0);
    clockModel();

    // Exit and accept on the same cycle
    step("col_exit", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkBit("col_exit.init_lit", ap_loop_init, 1'b1);
    clockModel();

    // Start and drain on the same cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("col_start");
    checkBit("col_start.done_lit", ap_done, 1'b1);
    clockModel();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("col_start.next");
    checkBit("col_start.next.done_lit", ap_done, 1'b0);
    clockModel();

    // Cache a done, then reset asynchronously between edges
    step("cache", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkBit("cache.done_lit", ap_done, 1'b1);
    checkBit("cache.init_lit", ap_loop_init, 1'b0);
    @(posedge ap_clk);
    #2;
    ap_rst_n          = 1'b0;
    awaitingFirstIter = 1'b1;
    doneSinceStart    = 1'b0;
    #1;
    checkOutput("async_rst");
    checkBit("async_rst.done_lit", ap_done, 1'b0);
    checkBit("async_rst.init_lit", ap_loop_init, 1'b1);
    step("async_rst.hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("async_rst.release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 2) != 0),
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 1) == 1);
      checkOutput($sformatf("rand.c%0d", c));
      clockModel();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
